// File: rtl/code_lock_fsm_pkg.sv
// Purpose: shared types and constants for the code lock.
// Contents: FSM state enum, symbol width, default stored code.
package code_lock_fsm_pkg;

   localparam int unsigned SYM_W = 2;

   // Symbol i lives in bits [2i+1:2i]; entry order is 3,1,2,0.
   localparam logic [7:0] DEFAULT_CODE = 8'b00_10_01_11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENTRY   = 2'd1,
      ST_OPEN    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_e;

endpackage

// File: rtl/code_lock_fsm_if.sv
// Purpose: symbol entry / lock status bundle between the switch front-end
// and the lock sequencer.
// Signals:
//   sym_in, sym_valid, clr         front-end -> lock
//   unlocked, lockout, fail_pulse,
//   pos, fail_cnt                  lock -> status outputs
interface code_lock_fsm_if #(
   parameter int unsigned N_SYM = 4
);
   import code_lock_fsm_pkg::*;

   localparam int unsigned POS_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;

   logic [SYM_W-1:0] sym_in;
   logic             sym_valid;
   logic             clr;
   logic             unlocked;
   logic             lockout;
   logic             fail_pulse;
   logic [POS_W-1:0] pos;
   logic [1:0]       fail_cnt;

   modport master (
      output sym_in, sym_valid, clr,
      input  unlocked, lockout, fail_pulse, pos, fail_cnt
   );

   modport slave (
      input  sym_in, sym_valid, clr,
      output unlocked, lockout, fail_pulse, pos, fail_cnt
   );

endinterface

// File: rtl/code_lock_fsm_eq2.sv
// Purpose: 2-bit equality comparator used as the lock's compare datapath.
// Ports:
//   a, b   in  2  operands
//   aeqb   out 1  high when a == b (combinational)
module eq2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       aeqb
);

   // Per-bit equality, then AND.
   logic e0;
   logic e1;

   assign e0   = (a[0] & b[0]) | (~a[0] & ~b[0]);
   assign e1   = (a[1] & b[1]) | (~a[1] & ~b[1]);
   assign aeqb = e0 & e1;

endmodule

// File: rtl/code_lock_fsm.sv
// Purpose: sequences a symbol-code lock. A full correct entry opens the lock
// for OPEN_CYCLES clocks; MAX_FAIL consecutive wrong entries force a
// LOCK_CYCLES lockout. A stalled partial entry is abandoned after
// ENTRY_TIMEOUT idle clocks.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of code_lock_fsm_if (symbol input, status outputs)
module code_lock_fsm
   import code_lock_fsm_pkg::*;
#(
   parameter int unsigned              N_SYM         = 4,
   parameter logic [SYM_W*N_SYM-1:0]  CODE          = (SYM_W*N_SYM)'(DEFAULT_CODE),
   parameter int unsigned              MAX_FAIL      = 3,
   parameter int unsigned              OPEN_CYCLES   = 16,
   parameter int unsigned              LOCK_CYCLES   = 32,
   parameter int unsigned              ENTRY_TIMEOUT = 64,
   parameter int unsigned              TMR_W         = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   code_lock_fsm_if.slave bus
);

   localparam int unsigned POS_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;

   localparam logic [POS_W-1:0] LAST_POS   = POS_W'(N_SYM - 1);
   localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCK_CYCLES - 1);
   localparam logic [TMR_W-1:0] TOUT_LAST  = TMR_W'(ENTRY_TIMEOUT - 1);
   localparam logic [2:0]       MAX_FAIL_3 = 3'(MAX_FAIL);

   state_e           state_q,      state_d;
   logic [POS_W-1:0] pos_q,        pos_d;
   logic [1:0]       fail_cnt_q,   fail_cnt_d;
   logic [TMR_W-1:0] timer_q,      timer_d;
   logic             mism_q,       mism_d;
   logic             unlocked_q,   unlocked_d;
   logic             lockout_q,    lockout_d;
   logic             fail_pulse_q, fail_pulse_d;

   logic [SYM_W-1:0] exp_sym_c;
   logic             match_c;
   logic             any_mism_c;
   logic [2:0]       fail_inc_c;

   // Stored code symbol selected by the current entry position.
   always_comb begin
      exp_sym_c = '0;
      for (int unsigned i = 0; i < N_SYM; i++) begin
         if (pos_q == POS_W'(i)) exp_sym_c = CODE[SYM_W*i +: SYM_W];
      end
   end

   eq2 u_eq2 (
      .a    (bus.sym_in),
      .b    (exp_sym_c),
      .aeqb (match_c)
   );

   // Mismatch status of the entry including the symbol currently presented.
   assign any_mism_c = mism_q | ~match_c;
   assign fail_inc_c = {1'b0, fail_cnt_q} + 3'd1;

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      fail_cnt_d   = fail_cnt_q;
      timer_d      = timer_q;
      mism_d       = mism_q;
      unlocked_d   = unlocked_q;
      lockout_d    = lockout_q;
      fail_pulse_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            pos_d   = '0;
            timer_d = '0;
            mism_d  = 1'b0;
            // clr wins over a coincident strobe; the symbol is dropped.
            if (!bus.clr && bus.sym_valid) begin
               mism_d  = ~match_c;
               pos_d   = POS_W'(1);
               state_d = ST_ENTRY;
            end
         end

         ST_ENTRY: begin
            if (bus.clr) begin
               state_d = ST_IDLE;
               pos_d   = '0;
               mism_d  = 1'b0;
               timer_d = '0;
            end else if (bus.sym_valid) begin
               timer_d = '0;
               if (pos_q == LAST_POS) begin
                  // Score the complete entry; no early reject before this.
                  pos_d  = '0;
                  mism_d = 1'b0;
                  if (!any_mism_c) begin
                     state_d    = ST_OPEN;
                     fail_cnt_d = '0;
                     unlocked_d = 1'b1;
                  end else if (fail_inc_c < MAX_FAIL_3) begin
                     state_d      = ST_IDLE;
                     fail_cnt_d   = fail_inc_c[1:0];
                     fail_pulse_d = 1'b1;
                  end else begin
                     state_d      = ST_LOCKOUT;
                     fail_cnt_d   = MAX_FAIL_3[1:0];
                     fail_pulse_d = 1'b1;
                     lockout_d    = 1'b1;
                  end
               end else begin
                  pos_d  = pos_q + POS_W'(1);
                  mism_d = any_mism_c;
               end
            end else if (timer_q >= TOUT_LAST) begin
               // Abandoned entry: back to idle without counting a failure.
               state_d = ST_IDLE;
               pos_d   = '0;
               mism_d  = 1'b0;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         ST_OPEN: begin
            if (timer_q >= OPEN_LAST) begin
               state_d    = ST_IDLE;
               unlocked_d = 1'b0;
               timer_d    = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         ST_LOCKOUT: begin
            if (timer_q >= LOCK_LAST) begin
               state_d    = ST_IDLE;
               lockout_d  = 1'b0;
               fail_cnt_d = '0;
               timer_d    = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         default: begin
            state_d    = ST_IDLE;
            pos_d      = '0;
            timer_d    = '0;
            mism_d     = 1'b0;
            unlocked_d = 1'b0;
            lockout_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         pos_q        <= '0;
         fail_cnt_q   <= '0;
         timer_q      <= '0;
         mism_q       <= 1'b0;
         unlocked_q   <= 1'b0;
         lockout_q    <= 1'b0;
         fail_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         fail_cnt_q   <= fail_cnt_d;
         timer_q      <= timer_d;
         mism_q       <= mism_d;
         unlocked_q   <= unlocked_d;
         lockout_q    <= lockout_d;
         fail_pulse_q <= fail_pulse_d;
      end
   end

   assign bus.unlocked   = unlocked_q;
   assign bus.lockout    = lockout_q;
   assign bus.fail_pulse = fail_pulse_q;
   assign bus.pos        = pos_q;
   assign bus.fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Purpose: self-checking bench for code_lock_fsm. Stimulus pushes expected
// lock events (open / fail / lockout) into a queue; a negedge monitor pops
// and checks them as the outputs rise and measures the open/lockout windows.
module tb_code_lock_fsm;
   import code_lock_fsm_pkg::*;

   localparam int OPEN_CYCLES = 16;
   localparam int LOCK_CYCLES = 32;

   typedef enum int {EV_OPEN = 0, EV_FAIL = 1, EV_LOCK = 2} ev_e;
   typedef struct {
      ev_e kind;
      int  fc;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   code_lock_fsm_if #(.N_SYM(4)) bus ();

   code_lock_fsm #(
      .N_SYM         (4),
      .CODE          (8'b00_10_01_11),
      .MAX_FAIL      (3),
      .OPEN_CYCLES   (16),
      .LOCK_CYCLES   (32),
      .ENTRY_TIMEOUT (64),
      .TMR_W         (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic push(ev_e k, int fc);
      exp_t e;
      e.kind = k;
      e.fc   = fc;
      exp_q.push_back(e);
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle strobe followed by one idle cycle.
   task automatic strobe(input logic [1:0] s, input logic c = 1'b0);
      bus.sym_in    = s;
      bus.sym_valid = 1'b1;
      bus.clr       = c;
      cycles(1);
      bus.sym_valid = 1'b0;
      bus.clr       = 1'b0;
      cycles(1);
   endtask

   task automatic enter4(input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] d);
      strobe(a);
      strobe(b);
      strobe(c);
      strobe(d);
   endtask

   // Monitor: pop and compare on each rising event, measure windows.
   task automatic take(ev_e k);
      exp_t e;
      chk("exp_q_has_entry", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("event_kind", int'(k), int'(e.kind));
         chk("fail_cnt_at_event", int'(bus.fail_cnt), e.fc);
         chk("pos_at_event", int'(bus.pos), 0);
      end
   endtask

   initial begin
      logic prev_unl = 1'b0;
      logic prev_lck = 1'b0;
      logic prev_fp  = 1'b0;
      bit   unl_trk  = 1'b0;
      bit   lck_trk  = 1'b0;
      int   unl_len  = 0;
      int   lck_len  = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_unl = 1'b0;
            prev_lck = 1'b0;
            prev_fp  = 1'b0;
            unl_trk  = 1'b0;
            lck_trk  = 1'b0;
         end else begin
            if (prev_fp) chk("fail_pulse_width", int'(bus.fail_pulse), 0);
            if (bus.fail_pulse && !prev_fp) take(EV_FAIL);
            if (bus.lockout && !prev_lck) begin
               take(EV_LOCK);
               lck_len = 0;
               lck_trk = 1'b1;
            end
            if (bus.unlocked && !prev_unl) begin
               take(EV_OPEN);
               unl_len = 0;
               unl_trk = 1'b1;
            end
            if (bus.unlocked) unl_len++;
            if (bus.lockout)  lck_len++;
            if (!bus.unlocked && prev_unl && unl_trk) begin
               chk("open_window_len", unl_len, OPEN_CYCLES);
               unl_trk = 1'b0;
            end
            if (!bus.lockout && prev_lck && lck_trk) begin
               chk("lockout_window_len", lck_len, LOCK_CYCLES);
               lck_trk = 1'b0;
            end
            prev_unl = bus.unlocked;
            prev_lck = bus.lockout;
            prev_fp  = bus.fail_pulse;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n       = 1'b0;
      bus.sym_in    = 2'd0;
      bus.sym_valid = 1'b0;
      bus.clr       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_unlocked",   int'(bus.unlocked),   0);
      chk("rst_lockout",    int'(bus.lockout),    0);
      chk("rst_fail_pulse", int'(bus.fail_pulse), 0);
      chk("rst_pos",        int'(bus.pos),        0);
      chk("rst_fail_cnt",   int'(bus.fail_cnt),   0);
      reset_n = 1'b1;
      cycles(2);

      // Correct entry; a strobe during OPEN is ignored.
      push(EV_OPEN, 0);
      strobe(2'd3);
      strobe(2'd1);
      chk("pos_mid_entry", int'(bus.pos), 2);
      strobe(2'd2);
      strobe(2'd0);
      chk("open_after_entry", int'(bus.unlocked), 1);
      strobe(2'd3);
      chk("pos_strobe_in_open", int'(bus.pos), 0);
      cycles(20);
      chk("open_closed", int'(bus.unlocked), 0);
      chk("open_fail_cnt", int'(bus.fail_cnt), 0);

      // Single wrong sequence.
      push(EV_FAIL, 1);
      enter4(2'd3, 2'd1, 2'd1, 2'd0);
      chk("wrong1_fail_cnt", int'(bus.fail_cnt), 1);
      chk("wrong1_pos",      int'(bus.pos),      0);
      chk("wrong1_unlocked", int'(bus.unlocked), 0);
      cycles(2);

      // Success clears the fail counter.
      push(EV_OPEN, 0);
      enter4(2'd3, 2'd1, 2'd2, 2'd0);
      cycles(20);
      chk("success_clears_fail_cnt", int'(bus.fail_cnt), 0);

      // Three wrong sequences -> lockout.
      push(EV_FAIL, 1);
      enter4(2'd0, 2'd0, 2'd0, 2'd0);
      cycles(1);
      push(EV_FAIL, 2);
      enter4(2'd3, 2'd1, 2'd2, 2'd1);
      cycles(1);
      push(EV_FAIL, 3);
      push(EV_LOCK, 3);
      enter4(2'd2, 2'd1, 2'd2, 2'd0);
      chk("lockout_high", int'(bus.lockout), 1);
      strobe(2'd3);
      chk("pos_strobe_in_lockout", int'(bus.pos), 0);
      strobe(2'd1, 1'b1);
      chk("pos_clr_in_lockout", int'(bus.pos), 0);
      chk("lockout_still_high", int'(bus.lockout), 1);
      cycles(32);
      chk("lockout_ended", int'(bus.lockout), 0);
      chk("lockout_fail_cnt_cleared", int'(bus.fail_cnt), 0);
      push(EV_OPEN, 0);
      enter4(2'd3, 2'd1, 2'd2, 2'd0);
      cycles(20);

      // Entry timeout leaves fail_cnt unchanged.
      push(EV_FAIL, 1);
      enter4(2'd1, 2'd1, 2'd1, 2'd1);
      cycles(2);
      strobe(2'd3);
      strobe(2'd1);
      chk("timeout_pos_start", int'(bus.pos), 2);
      cycles(62);
      chk("timeout_pos_before", int'(bus.pos), 2);
      cycles(1);
      chk("timeout_pos_after", int'(bus.pos), 0);
      chk("timeout_fail_cnt", int'(bus.fail_cnt), 1);

      // clr coincident with the second strobe drops the symbol.
      strobe(2'd3);
      chk("clr_pos_before", int'(bus.pos), 1);
      strobe(2'd1, 1'b1);
      chk("clr_pos_after", int'(bus.pos), 0);
      chk("clr_fail_cnt", int'(bus.fail_cnt), 1);

      // Reset during OPEN (cycle 5 of 16).
      push(EV_OPEN, 0);
      enter4(2'd3, 2'd1, 2'd2, 2'd0);
      cycles(3);
      chk("open_before_reset", int'(bus.unlocked), 1);
      reset_n = 1'b0;
      #1;
      chk("async_reset_unlocked", int'(bus.unlocked), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cycles(2);
      chk("post_reset_unlocked", int'(bus.unlocked), 0);
      chk("post_reset_lockout",  int'(bus.lockout),  0);
      chk("post_reset_pos",      int'(bus.pos),      0);
      chk("post_reset_fail_cnt", int'(bus.fail_cnt), 0);
      push(EV_OPEN, 0);
      enter4(2'd3, 2'd1, 2'd2, 2'd0);
      cycles(20);

      cycles(5);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
